uart_rx_byte: RTL and testbench

- Receives one 8N1 UART frame (start, 8 data LSB-first, 1 stop) on Uart_rx and presents the byte with a one-cycle done pulse.
- Receive-side companion of the byte transmitter. It uses the same Baud_sel encoding so a board loopback (tx→rx) works with one shared select value.
- 16x oversampling with 3-sample majority vote per bit. It detects false starts and framing errors.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_rx_byte_if.sv | 23 ++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_rx_byte.sv | 125 ++++++++++++
 tb/tb_uart_rx_byte.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select codes, oversample divisors, sample points
// and receiver state encodings. The byte transmitter uses the same package.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Sub-bit positions of the three majority-vote samples, and counter limits.
  localparam logic [3:0] SAMPLE_FIRST  = 4'd6;
  localparam logic [3:0] SAMPLE_MID    = 4'd7;
  localparam logic [3:0] SAMPLE_LAST   = 4'd8;
  localparam logic [3:0] SUB_LAST      = 4'd15;
  localparam logic [3:0] BIT_LAST_DATA = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Unused select codes fall back to 9600 baud.
  function automatic int baud_rate(input logic [2:0] sel);
    int rate;
    case (sel)
      BAUD_19200:  rate = 19200;
      BAUD_38400:  rate = 38400;
      BAUD_57600:  rate = 57600;
      BAUD_115200: rate = 115200;
      default:     rate = 9600;
    endcase
    return rate;
  endfunction

  function automatic int baud_div(input int clk_freq, input logic [2:0] sel);
    return clk_freq / (baud_rate(sel) * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Pin group of the byte receiver: line and baud select in, byte and status out.
// There is no flow control: Rx_done is a one-cycle strobe and must be taken when it occurs.
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic [2:0] Baud_sel;
  logic       Uart_rx;
  logic [7:0] Data_byte;
  logic       Rx_done;
  logic       Frame_err;
  logic       Uart_state;
  rx_state_e  rx_state;

  modport master (
    output Baud_sel, Uart_rx,
    input  Data_byte, Rx_done, Frame_err, Uart_state, rx_state
  );

  modport slave (
    input  Baud_sel, Uart_rx,
    output Data_byte, Rx_done, Frame_err, Uart_state, rx_state
  );
endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator. Held at zero while disabled so that enabling it
// starts a fresh bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       enable,
  input  logic [2:0] baud_sel,
  output logic       tick
);

  localparam logic [15:0] DIV_9600_M1   = 16'(baud_div(CLK_FREQ, BAUD_9600) - 1);
  localparam logic [15:0] DIV_19200_M1  = 16'(baud_div(CLK_FREQ, BAUD_19200) - 1);
  localparam logic [15:0] DIV_38400_M1  = 16'(baud_div(CLK_FREQ, BAUD_38400) - 1);
  localparam logic [15:0] DIV_57600_M1  = 16'(baud_div(CLK_FREQ, BAUD_57600) - 1);
  localparam logic [15:0] DIV_115200_M1 = 16'(baud_div(CLK_FREQ, BAUD_115200) - 1);

  logic [15:0] div_m1;
  logic [15:0] cnt;

  always_comb begin
    div_m1 = DIV_9600_M1;
    case (baud_sel)
      BAUD_19200:  div_m1 = DIV_19200_M1;
      BAUD_38400:  div_m1 = DIV_38400_M1;
      BAUD_57600:  div_m1 = DIV_57600_M1;
      BAUD_115200: div_m1 = DIV_115200_M1;
      default:     div_m1 = DIV_9600_M1;
    endcase
  end

  assign tick = enable && (cnt == div_m1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 16x oversampling, 3-sample majority per bit, false-start and
// framing-error detection. The frame ends mid stop bit so back-to-back frames are caught.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input logic          Clk,
  input logic          Rst_n,
  uart_rx_byte_if.slave bus
);

  logic       sync1, sync2, sync3;
  logic       fall;
  rx_state_e  state, state_next;
  logic [2:0] baud_lat;
  logic       tick;
  logic [3:0] sub_cnt;
  logic [3:0] bit_idx;
  logic [2:0] data_pos;
  logic       s_first, s_mid;
  logic       maj;
  logic       sample_last;
  logic       bit_end;
  logic       stop_decide;
  logic [7:0] shift_reg;
  logic [7:0] data_q;
  logic       done_q, ferr_q;

  // Synchronizer idles high so reset never fabricates a falling edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= bus.Uart_rx;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign fall = !sync2 && sync3;

  uart_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .enable   (state != ST_IDLE),
    .baud_sel (baud_lat),
    .tick     (tick)
  );

  // The third sample is the live synchronized line at the sub-count 8 tick.
  assign maj         = (s_first & s_mid) | (s_first & sync2) | (s_mid & sync2);
  assign sample_last = tick && (sub_cnt == SAMPLE_LAST);
  assign bit_end     = tick && (sub_cnt == SUB_LAST);
  assign stop_decide = (state == ST_STOP) && sample_last && !(done_q || ferr_q);
  assign data_pos    = 3'(bit_idx - 4'd1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (fall) state_next = ST_START;
      ST_START: begin
        if (sample_last && maj) state_next = ST_IDLE;
        else if (bit_end)       state_next = ST_DATA;
      end
      ST_DATA:  if (bit_end && (bit_idx == BIT_LAST_DATA)) state_next = ST_STOP;
      // Leave only after the result pulse so it is seen with Uart_state high.
      ST_STOP:  if (done_q || ferr_q) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      baud_lat  <= BAUD_9600;
      sub_cnt   <= '0;
      bit_idx   <= '0;
      s_first   <= 1'b1;
      s_mid     <= 1'b1;
      shift_reg <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      if (state == ST_IDLE) begin
        sub_cnt <= '0;
        bit_idx <= '0;
        if (fall) baud_lat <= bus.Baud_sel;
      end else if (tick) begin
        sub_cnt <= sub_cnt + 4'd1;
        if (sub_cnt == SUB_LAST)     bit_idx <= bit_idx + 4'd1;
        if (sub_cnt == SAMPLE_FIRST) s_first <= sync2;
        if (sub_cnt == SAMPLE_MID)   s_mid   <= sync2;
      end
      if ((state == ST_DATA) && sample_last) shift_reg[data_pos] <= maj;
      if (stop_decide) begin
        if (maj) begin
          data_q <= shift_reg;
          done_q <= 1'b1;
        end else begin
          ferr_q <= 1'b1;
        end
      end
    end
  end

  assign bus.Data_byte  = data_q;
  assign bus.Rx_done    = done_q;
  assign bus.Frame_err  = ferr_q;
  assign bus.Uart_state = (state != ST_IDLE);
  assign bus.rx_state   = state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at a 10 MHz clock (divisors 65/32/16/10/5):
// a frame table plus hand-written latency, back-to-back, glitch, noise and reset cases.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int CLK_FREQ_TB = 10_000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_line = 1'b1;
  logic spike = 1'b0;

  always #5 clk = ~clk;

  uart_rx_byte_if bus ();
  assign bus.Uart_rx = tx_line ^ spike;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ_TB)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_done;
    logic       exp_ferr;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  logic [7:0] exp_last;
  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;

  // Divisors of a 10 MHz clock at 16x, worked out by hand.
  function automatic int tb_div(input logic [2:0] sel);
    case (sel)
      3'd1:    return 32;
      3'd2:    return 16;
      3'd3:    return 10;
      3'd4:    return 5;
      default: return 65;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [2:0] sel, input logic [7:0] data, input logic stop_bit);
    int         bit_cycles;
    logic [9:0] frame;
    bit_cycles   = 16 * tb_div(sel);
    frame        = {stop_bit, data, 1'b0};
    bus.Baud_sel = sel;
    for (int i = 0; i < 10; i++) begin
      tx_line = frame[i];
      repeat (bit_cycles) @(negedge clk);
    end
    tx_line = 1'b1;
  endtask

  // Scoreboard and pulse protocol monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.Rx_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rx_done: actual byte=%0h required=no pulse", bus.Data_byte);
        end else begin
          check("rx_byte", {24'h0, bus.Data_byte}, {24'h0, exp_q.pop_front()});
        end
      end
      if (bus.Frame_err) ferr_cnt++;
      if (bus.Rx_done && bus.Frame_err) begin
        n_err++;
        $display("FAIL pulse_exclusive: actual=both high required=at most one");
      end
      if ((bus.Rx_done || bus.Frame_err) && !bus.Uart_state) begin
        n_err++;
        $display("FAIL pulse_in_idle: actual=pulse with Uart_state=0 required=no pulse in idle");
      end
    end
  end

  initial begin
    int done0, ferr0, lat, exp_lat, t_low;
    logic seen_high;

    vecs[0] = '{3'd4, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{3'd2, 8'h55, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{3'd3, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'd1, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{3'd7, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{3'd4, 8'h81, 1'b0, 1'b0, 1'b1};

    bus.Baud_sel = 3'd0;
    repeat (4) @(negedge clk);
    check("reset_data_byte", {24'h0, bus.Data_byte}, 32'h0);
    check("reset_rx_done", {31'h0, bus.Rx_done}, 32'h0);
    check("reset_frame_err", {31'h0, bus.Frame_err}, 32'h0);
    check("reset_uart_state", {31'h0, bus.Uart_state}, 32'h0);
    check("reset_fsm_state", {30'h0, bus.rx_state}, {30'h0, ST_IDLE});
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_last = 8'h00;

    // Basic receive at 9600 with latency measured from the start-bit edge.
    exp_q.push_back(8'hA5);
    exp_last = 8'hA5;
    ferr0    = ferr_cnt;
    exp_lat  = 153 * 65 + 2;
    lat      = 0;
    fork
      send_frame(3'd0, 8'hA5, 1'b1);
      begin
        while (bus.Rx_done !== 1'b1 && lat < 20000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    n_vec++;
    if (lat < exp_lat - 3 || lat > exp_lat + 3) begin
      n_err++;
      $display("FAIL basic_latency: actual=%0d required=%0d+-3", lat, exp_lat);
    end
    check("basic_data_byte", {24'h0, bus.Data_byte}, 32'hA5);
    check("basic_no_ferr", ferr_cnt - ferr0, 0);

    // Back-to-back frames at 115200 with no idle gap.
    repeat (20) @(negedge clk);
    done0 = done_cnt;
    ferr0 = ferr_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(3'd4, 8'h3C, 1'b1);
    send_frame(3'd4, 8'hC3, 1'b1);
    exp_last = 8'hC3;
    check("b2b_done_count", done_cnt - done0, 2);
    check("b2b_no_ferr", ferr_cnt - ferr0, 0);
    check("b2b_data_byte", {24'h0, bus.Data_byte}, 32'hC3);

    // Frame table.
    for (int v = 0; v < 6; v++) begin
      repeat (20) @(negedge clk);
      done0 = done_cnt;
      ferr0 = ferr_cnt;
      if (vecs[v].exp_done) begin
        exp_q.push_back(vecs[v].data);
        exp_last = vecs[v].data;
      end
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].stop_bit);
      check($sformatf("vec%0d_done", v), done_cnt - done0, {31'h0, vecs[v].exp_done});
      check($sformatf("vec%0d_ferr", v), ferr_cnt - ferr0, {31'h0, vecs[v].exp_ferr});
      check($sformatf("vec%0d_data", v), {24'h0, bus.Data_byte}, {24'h0, exp_last});
    end

    // False start: 3 us low glitch at 9600.
    repeat (20) @(negedge clk);
    done0        = done_cnt;
    ferr0        = ferr_cnt;
    bus.Baud_sel = 3'd0;
    seen_high    = 1'b0;
    tx_line      = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen_high |= bus.Uart_state;
    end
    tx_line = 1'b1;
    t_low   = 30;
    while (bus.Uart_state && t_low < 16 * 65) begin
      @(negedge clk);
      t_low++;
    end
    check("false_start_rise", {31'h0, seen_high}, 32'h1);
    check("false_start_abort", {31'h0, bus.Uart_state}, 32'h0);
    repeat (16 * 65) @(negedge clk);
    check("false_start_done", done_cnt - done0, 0);
    check("false_start_ferr", ferr_cnt - ferr0, 0);
    check("false_start_data", {24'h0, bus.Data_byte}, {24'h0, exp_last});

    // Noise: one-clock inverted spike on the sub-count 7 sample of data bit 3.
    repeat (20) @(negedge clk);
    exp_q.push_back(8'hF0);
    exp_last = 8'hF0;
    fork
      send_frame(3'd4, 8'hF0, 1'b1);
      begin
        repeat ((16 * 4 + 8) * 5) @(negedge clk);
        spike = 1'b1;
        @(negedge clk);
        spike = 1'b0;
      end
    join
    check("noise_data_byte", {24'h0, bus.Data_byte}, 32'hF0);

    // Reset during data bit 4, then a clean frame.
    repeat (20) @(negedge clk);
    done0 = done_cnt;
    ferr0 = ferr_cnt;
    fork
      send_frame(3'd4, 8'hE7, 1'b1);
      begin
        repeat ((16 * 5 + 8) * 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data_byte", {24'h0, bus.Data_byte}, 32'h0);
        check("midrst_uart_state", {31'h0, bus.Uart_state}, 32'h0);
        check("midrst_rx_done", {31'h0, bus.Rx_done}, 32'h0);
        check("midrst_frame_err", {31'h0, bus.Frame_err}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    exp_last = 8'h00;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt - done0, 0);
    check("midrst_no_ferr", ferr_cnt - ferr0, 0);
    exp_q.push_back(8'h81);
    exp_last = 8'h81;
    send_frame(3'd4, 8'h81, 1'b1);
    check("post_rst_data", {24'h0, bus.Data_byte}, 32'h81);
    check("post_rst_done", done_cnt - done0, 1);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
